int_exec_unit: RTL and testbench
================================

// Module: int_exec_unit
// PURPOSE
// - Integer execution unit directly downstream of the integer issue queue.
// - Accepts one ready instruction per handshake, computes an ALU result, holds it in a result register, and requests the CDB.
// - Broadcasts the result and rd_tag once the CDB arbiter grants the request.
// - ALU ops are single-cycle; MUL is multi-cycle (MUL_LAT).
// PARAMETERS
// - DATA_W   32  operand/result width
// - TAG_W    6   ROB/physical tag width
// - MUL_LAT  3   cycles from accept to result valid for MUL; legal range 1..15
// PORTS
// - clk               in   1       clock, rising edge
// - reset             in   1       asynchronous, active-high
// - issueque_ready    in   1       issue queue has a ready instruction on the issueque_* bus
// - issueque_rs_data  in   DATA_W  operand A
// - issueque_rt_data  in   DATA_W  operand B
// - issueque_rd_tag   in   TAG_W   destination tag
// - issueque_opcode   in   3       ALU op, encoding below
// - issueblk_done     out  1       accept strobe; the issue queue removes the entry on clk when this and issueque_ready are both 1
// - exu_cdb_req       out  1       result held, requesting CDB
// - exu_cdb_tag       out  TAG_W   tag of held result
// - exu_cdb_data      out  DATA_W  held result
// - cdb_grant         in   1       arbiter grant; broadcast occurs in a cycle where req=1 and grant=1
// - exu_busy          out  1       state != IDLE
// BEHAVIOUR
// - Opcodes:
//   - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR
//   - 101 SLL and 110 SRL, shift amount = rt[4:0]
//   - 111 MUL, low DATA_W bits of the unsigned product
//   - ADD/SUB wrap modulo 2^DATA_W; no flags.
// - FSM states: IDLE, EXEC (MUL only), WB.
// - accept = issueque_ready & (state==IDLE | (state==WB & cdb_grant)).
// - issueblk_done = accept, combinational. It is never asserted when issueque_ready=0.
// - On accept of a non-MUL op: result and tag are registered at that edge; next state WB. exu_cdb_req=1 in the following cycle (latency 1).
// - On accept of MUL: operands, tag and a counter are latched, counter = MUL_LAT-1.
//   - If MUL_LAT=1, go directly to WB with the product.
//   - Otherwise go to EXEC. Decrement each cycle; at 0, register the product and go to WB. exu_cdb_req rises exactly MUL_LAT cycles after the accept edge.
// - WB: exu_cdb_req=1. tag and data stay stable until granted.
//   - grant & !accept: go to IDLE, req=0 next cycle.
//   - grant & accept: back-to-back. New op loads at the same edge with no bubble.
//   - no grant: hold indefinitely; issueblk_done stays 0 (backpressure).
// - EXEC: issueblk_done=0; cdb_grant is ignored.
// - Inputs are sampled only on accept. Changes to issueque_* in other cycles have no effect.
// - Reset values: state=IDLE, exu_cdb_req=0, exu_cdb_tag=0, exu_cdb_data=0, exu_busy=0, counter=0.
//   - issueblk_done=0 follows from state=IDLE only when issueque_ready=0.
// - Reset mid-operation: the in-flight result is discarded and never broadcast.
// STRUCTURE
// - Shared package/include: alu_op_t enum (3-bit encodings above), exu_state_t enum, TAG_W/DATA_W constants.
// - Sub-module int_alu: purely combinational (a, b, op) -> result, including MUL.
// - Top level holds the FSM, MUL counter and result registers.
// TESTING
// - Reset, then idle -> req=0, done=0, tag/data=0.
// - ADD 5+7, tag 0x0A, grant held 1 -> done pulses 1 cycle; next cycle req=1, tag=0x0A, data=12; then req=0.
// - SUB 0-1 -> data=0xFFFFFFFF.
// - SLL 1<<35 (rt=35) -> data=0x8 (shift uses rt[4:0]=3).
// - MUL 6*7 with MUL_LAT=3 -> req rises 3 cycles after the accept edge, data=42; done=0 during EXEC even with issueque_ready=1.
// - Hold grant=0 for 4 cycles in WB with issueque_ready=1 -> done=0 and tag/data stable.
//   - Then grant=1 with next op XOR 0xF0^0xFF -> same-cycle done; next cycle data=0x0F.
// - Assert reset during EXEC of a MUL -> req never rises and all outputs return to reset values.

Source files
------------

// File: rtl/int_exec_unit_pkg.sv
// Shared types and constants for the integer execution unit.
package int_exec_unit_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 6;
    // Wide enough for MUL_LAT-1 with MUL_LAT up to 15.
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpOr  = 3'b011,
        OpXor = 3'b100,
        OpSll = 3'b101,
        OpSrl = 3'b110,
        OpMul = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StWb   = 2'b10
    } exu_state_t;

endpackage

// File: rtl/int_exec_unit_alu.sv
// Purely combinational integer ALU, including the low half of an unsigned multiply.
module int_alu
    import int_exec_unit_pkg::*;
#(
    parameter int unsigned DATA_W = int_exec_unit_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  alu_op_t           op,
    output logic [DATA_W-1:0] result
);

    // Decode the opcode into one result; arithmetic wraps, no flags.
    always_comb begin
        result = '0;
        unique case (op)
            OpAdd:   result = a + b;
            OpSub:   result = a - b;
            OpAnd:   result = a & b;
            OpOr:    result = a | b;
            OpXor:   result = a ^ b;
            OpSll:   result = a << b[4:0];
            OpSrl:   result = a >> b[4:0];
            OpMul:   result = a * b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/int_exec_unit.sv
// Integer execution unit: accepts from the issue queue, computes, holds the result
// and requests the CDB until granted. MUL takes MUL_LAT cycles, everything else one.
module int_exec_unit
    import int_exec_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = int_exec_unit_pkg::DATA_W,
    parameter int unsigned TAG_W   = int_exec_unit_pkg::TAG_W,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issueque_ready,
    input  logic [DATA_W-1:0] issueque_rs_data,
    input  logic [DATA_W-1:0] issueque_rt_data,
    input  logic [TAG_W-1:0]  issueque_rd_tag,
    input  logic [2:0]        issueque_opcode,
    output logic              issueblk_done,
    output logic              exu_cdb_req,
    output logic [TAG_W-1:0]  exu_cdb_tag,
    output logic [DATA_W-1:0] exu_cdb_data,
    input  logic              cdb_grant,
    output logic              exu_busy
);

    exu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              accept;
    alu_op_t           op_in;
    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_a, alu_b, alu_res;

    assign op_in  = alu_op_t'(issueque_opcode);
    // A held result frees the unit in the same cycle it is granted, so back-to-back works.
    assign accept = issueque_ready &
                    ((state_q == StIdle) | ((state_q == StWb) & cdb_grant));

    // In EXEC the ALU finishes the latched MUL; otherwise it sees the issue bus directly.
    always_comb begin
        alu_a  = issueque_rs_data;
        alu_b  = issueque_rt_data;
        alu_op = op_in;
        if (state_q == StExec) begin
            alu_a  = opa_q;
            alu_b  = opb_q;
            alu_op = OpMul;
        end
    end

    int_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_res)
    );

    // Next-state logic for the FSM, MUL counter and result registers.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        tag_d   = tag_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle, StWb: begin
                if (accept) begin
                    tag_d = issueque_rd_tag;
                    if (op_in == OpMul && MUL_LAT > 1) begin
                        opa_d   = issueque_rs_data;
                        opb_d   = issueque_rt_data;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                        state_d = StExec;
                    end else begin
                        data_d  = alu_res;
                        state_d = StWb;
                    end
                end else if (state_q == StWb && cdb_grant) begin
                    state_d = StIdle;
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    data_d  = alu_res;
                    state_d = StWb;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset drops any in-flight result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign issueblk_done = accept;
    assign exu_cdb_req   = (state_q == StWb);
    assign exu_cdb_tag   = tag_q;
    assign exu_cdb_data  = data_q;
    assign exu_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_int_exec_unit.sv
// Directed bench for int_exec_unit with a result scoreboard.
module tb_int_exec_unit;
    import int_exec_unit_pkg::*;

    localparam int unsigned MUL_LAT = 3;

    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              issueque_ready = 1'b0;
    logic [DATA_W-1:0] issueque_rs_data = '0;
    logic [DATA_W-1:0] issueque_rt_data = '0;
    logic [TAG_W-1:0]  issueque_rd_tag = '0;
    logic [2:0]        issueque_opcode = '0;
    logic              issueblk_done;
    logic              exu_cdb_req;
    logic [TAG_W-1:0]  exu_cdb_tag;
    logic [DATA_W-1:0] exu_cdb_data;
    logic              cdb_grant = 1'b0;
    logic              exu_busy;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    int_exec_unit #(
        .DATA_W  (DATA_W),
        .TAG_W   (TAG_W),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .issueque_ready   (issueque_ready),
        .issueque_rs_data (issueque_rs_data),
        .issueque_rt_data (issueque_rt_data),
        .issueque_rd_tag  (issueque_rd_tag),
        .issueque_opcode  (issueque_opcode),
        .issueblk_done    (issueblk_done),
        .exu_cdb_req      (exu_cdb_req),
        .exu_cdb_tag      (exu_cdb_tag),
        .exu_cdb_data     (exu_cdb_data),
        .cdb_grant        (cdb_grant),
        .exu_busy         (exu_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] model(input logic [2:0] op,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] p;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a << b[4:0];
            3'd6: return a >> b[4:0];
            default: begin
                p = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
                return p[DATA_W-1:0];
            end
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic issue(input alu_op_t op, input logic [DATA_W-1:0] a,
                         input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] tag);
        issueque_ready   = 1'b1;
        issueque_opcode  = op;
        issueque_rs_data = a;
        issueque_rt_data = b;
        issueque_rd_tag  = tag;
    endtask

    // Settle, record accepts and broadcasts into the scoreboard, then advance one cycle.
    task automatic tick();
        exp_t e;
        #1;
        if (issueblk_done && !issueque_ready) check("done_without_ready", 1, 0);
        if (exu_cdb_req && cdb_grant) begin
            if (sb.size() == 0) begin
                check("unexpected_broadcast", 1, 0);
            end else begin
                e = sb.pop_front();
                check("sb_tag", 32'(exu_cdb_tag), 32'(e.tag));
                check("sb_data", exu_cdb_data, e.data);
            end
        end
        if (issueblk_done && issueque_ready) begin
            e.tag  = issueque_rd_tag;
            e.data = model(issueque_opcode, issueque_rs_data, issueque_rt_data);
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset, then idle outputs
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_req", 32'(exu_cdb_req), 0);
        check("rst_done", 32'(issueblk_done), 0);
        check("rst_tag", 32'(exu_cdb_tag), 0);
        check("rst_data", exu_cdb_data, 0);
        check("rst_busy", 32'(exu_busy), 0);

        // ADD 5+7, grant held
        cdb_grant = 1'b1;
        issue(OpAdd, 5, 7, 6'h0A);
        #1 check("add_done", 32'(issueblk_done), 1);
        tick();
        issueque_ready = 1'b0;
        #1;
        check("add_done_pulse", 32'(issueblk_done), 0);
        check("add_req", 32'(exu_cdb_req), 1);
        check("add_tag", 32'(exu_cdb_tag), 32'h0A);
        check("add_data", exu_cdb_data, 12);
        tick();
        check("add_req_drop", 32'(exu_cdb_req), 0);
        check("add_idle", 32'(exu_busy), 0);

        // SUB wraps
        issue(OpSub, 0, 1, 6'h11);
        tick();
        issueque_ready = 1'b0;
        #1 check("sub_data", exu_cdb_data, 32'hFFFF_FFFF);
        tick();

        // SLL uses rt[4:0]
        issue(OpSll, 1, 35, 6'h12);
        tick();
        issueque_ready = 1'b0;
        #1 check("sll_data", exu_cdb_data, 32'h8);
        tick();

        // MUL: no done during EXEC, req exactly MUL_LAT cycles after accept
        issue(OpMul, 6, 7, 6'h13);
        tick();
        for (int i = 0; i < int'(MUL_LAT); i++) begin
            issue(OpAdd, 1, 1, 6'h14);
            #1;
            check("mul_req_low", 32'(exu_cdb_req), 0);
            check("mul_done_low", 32'(issueblk_done), 0);
            check("mul_busy", 32'(exu_busy), 1);
            tick();
        end
        #1;
        check("mul_req", 32'(exu_cdb_req), 1);
        check("mul_data", exu_cdb_data, 42);
        // Back-to-back ADD accepted in the granted WB cycle
        check("b2b_done", 32'(issueblk_done), 1);
        tick();

        // Backpressure with the ADD result held
        cdb_grant = 1'b0;
        issue(OpXor, 32'hF0, 32'hFF, 6'h15);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_done", 32'(issueblk_done), 0);
            check("bp_req", 32'(exu_cdb_req), 1);
            check("bp_tag", 32'(exu_cdb_tag), 32'h14);
            check("bp_data", exu_cdb_data, 2);
            tick();
        end
        cdb_grant = 1'b1;
        #1 check("xor_done", 32'(issueblk_done), 1);
        tick();
        issueque_ready = 1'b0;
        #1;
        check("xor_tag", 32'(exu_cdb_tag), 32'h15);
        check("xor_data", exu_cdb_data, 32'h0F);
        tick();
        check("xor_idle", 32'(exu_cdb_req), 0);

        // Reset during EXEC discards the MUL
        issue(OpMul, 3, 3, 6'h16);
        tick();
        issueque_ready = 1'b0;
        tick();
        reset = 1'b1;
        sb.delete();
        #1;
        check("mrst_req", 32'(exu_cdb_req), 0);
        check("mrst_busy", 32'(exu_busy), 0);
        check("mrst_tag", 32'(exu_cdb_tag), 0);
        check("mrst_data", exu_cdb_data, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1 check("mrst_no_req", 32'(exu_cdb_req), 0);
            tick();
        end
        check("sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
